// File: rtl/sae_min_select.sv
// Minimum-SAE selector: scans one frame of raster-ordered candidate SAEs and
// reports the best candidate as a signed motion vector about the window centre.
module sae_min_select #(
   parameter int N     = 46,
   parameter int M     = 16,
   parameter int SAE_W = 16,
   parameter int MV_W  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [SAE_W-1:0] s_sae,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [MV_W-1:0]  m_mv_x,
   output logic [MV_W-1:0]  m_mv_y,
   output logic [SAE_W-1:0] m_sae,
   output logic             m_err
);

   localparam int P  = N - M + 1;
   localparam int C  = (N - M) / 2;
   localparam int XW = (P > 1) ? $clog2(P) : 1;

   typedef enum logic [0:0] {ACCUM = 1'b0, DONE = 1'b1} state_t;

   // Raster coordinate to signed offset; modular subtraction gives two's complement.
   function automatic logic [MV_W-1:0] to_mv(input logic [XW-1:0] idx);
      return MV_W'(idx) - MV_W'(C);
   endfunction

   state_t            state_r, state_n;
   logic [XW-1:0]     cx_r, cx_n, cy_r, cy_n;
   logic [XW-1:0]     best_cx_r, best_cx_n, best_cy_r, best_cy_n;
   logic [SAE_W-1:0]  best_sae_r, best_sae_n;
   logic              first_r, first_n;
   logic [MV_W-1:0]   mv_x_n, mv_y_n;
   logic [SAE_W-1:0]  sae_n;
   logic              err_n;
   logic              take_s, final_s;

   // Next-state, scan bookkeeping and result capture.
   always_comb begin
      state_n    = state_r;
      cx_n       = cx_r;
      cy_n       = cy_r;
      best_cx_n  = best_cx_r;
      best_cy_n  = best_cy_r;
      best_sae_n = best_sae_r;
      first_n    = first_r;
      mv_x_n     = m_mv_x;
      mv_y_n     = m_mv_y;
      sae_n      = m_sae;
      err_n      = m_err;
      take_s     = 1'b0;
      final_s    = 1'b0;
      case (state_r)
         ACCUM: begin
            if (s_valid && s_ready) begin
               final_s = (cx_r == XW'(P - 1)) && (cy_r == XW'(P - 1));
               // Strict less-than keeps the earliest candidate on ties.
               take_s  = first_r || (s_sae < best_sae_r);
               first_n = 1'b0;
               if (take_s) begin
                  best_sae_n = s_sae;
                  best_cx_n  = cx_r;
                  best_cy_n  = cy_r;
               end else begin
                  best_sae_n = best_sae_r;
               end
               if (s_last || final_s) begin
                  state_n = DONE;
                  cx_n    = '0;
                  cy_n    = '0;
                  mv_x_n  = to_mv(best_cx_n);
                  mv_y_n  = to_mv(best_cy_n);
                  sae_n   = best_sae_n;
                  err_n   = s_last ^ final_s;
               end else if (cx_r == XW'(P - 1)) begin
                  cx_n = '0;
                  cy_n = cy_r + XW'(1);
               end else begin
                  cx_n = cx_r + XW'(1);
               end
            end else begin
               state_n = ACCUM;
            end
         end
         DONE: begin
            if (m_ready) begin
               state_n = ACCUM;
               cx_n    = '0;
               cy_n    = '0;
               first_n = 1'b1;
            end else begin
               state_n = DONE;
            end
         end
         default: begin
            state_n = ACCUM;
            cx_n    = '0;
            cy_n    = '0;
            first_n = 1'b1;
         end
      endcase
   end

   // State, scan and registered output update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ACCUM;
         cx_r       <= '0;
         cy_r       <= '0;
         best_cx_r  <= '0;
         best_cy_r  <= '0;
         best_sae_r <= '0;
         first_r    <= 1'b1;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_mv_x     <= '0;
         m_mv_y     <= '0;
         m_sae      <= '0;
         m_err      <= 1'b0;
      end else begin
         state_r    <= state_n;
         cx_r       <= cx_n;
         cy_r       <= cy_n;
         best_cx_r  <= best_cx_n;
         best_cy_r  <= best_cy_n;
         best_sae_r <= best_sae_n;
         first_r    <= first_n;
         s_ready    <= (state_n == ACCUM);
         m_valid    <= (state_n == DONE);
         m_mv_x     <= mv_x_n;
         m_mv_y     <= mv_y_n;
         m_sae      <= sae_n;
         m_err      <= err_n;
      end
   end

endmodule

// File: tb/tb_sae_min_select.sv
// Self-checking bench for sae_min_select: directed and randomized frames scored
// against a plain arithmetic minimum-search model.
module tb_sae_min_select;

   localparam int N = 46, M = 16, SAE_W = 16, MV_W = 6;
   localparam int P = N - M + 1, C = (N - M) / 2, NC = P * P;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [SAE_W-1:0] s_sae = '0;
   logic             s_last = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b1;
   logic [MV_W-1:0]  m_mv_x, m_mv_y;
   logic [SAE_W-1:0] m_sae;
   logic             m_err;

   int checks = 0;
   int fails  = 0;
   logic [SAE_W-1:0] sae_q [NC];
   logic [MV_W-1:0]  exp_x, exp_y;
   logic [SAE_W-1:0] exp_sae;
   logic             exp_err;

   always #5 clk = ~clk;

   sae_min_select #(.N(N), .M(M), .SAE_W(SAE_W), .MV_W(MV_W)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sae(s_sae),
      .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_mv_x(m_mv_x),
      .m_mv_y(m_mv_y), .m_sae(m_sae), .m_err(m_err)
   );

   task automatic fill(input int lo, input int hi);
      for (int i = 0; i < NC; i++) sae_q[i] = SAE_W'($urandom_range(hi, lo));
   endtask

   task automatic drive_beats(input int n, input int last_at, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(7, 0) == 0) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_sae   = sae_q[i];
         s_last  = (i == last_at);
         for (int k = 0; k < 50 && !s_ready; k++) begin
            @(posedge clk); #1;
         end
         if (!s_ready) begin
            ok = 1'b0;
            s_valid = 1'b0;
            s_last = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic run_frame(input string name, input int n, input int last_at, input bit hold);
      int best;
      bit ok;
      m_ready = !hold;
      drive_beats(n, last_at, ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s timeout: s_ready=%b, required 1", name, s_ready);
         return;
      end
      best = 0;
      for (int i = 1; i < n; i++) if (sae_q[i] < sae_q[best]) best = i;
      exp_x   = MV_W'(best % P - C);
      exp_y   = MV_W'(best / P - C);
      exp_sae = sae_q[best];
      exp_err = (n != NC) || (last_at != n - 1);
      checks++;
      if (m_valid !== 1'b1) begin
         fails++; $display("FAIL %s m_valid: got %b, required 1", name, m_valid);
      end
      checks++;
      if (m_mv_x !== exp_x || m_mv_y !== exp_y) begin
         fails++;
         $display("FAIL %s mv: got (%0d,%0d), required (%0d,%0d)", name,
                  $signed(m_mv_x), $signed(m_mv_y), $signed(exp_x), $signed(exp_y));
      end
      checks++;
      if (m_sae !== exp_sae) begin
         fails++; $display("FAIL %s m_sae: got %0d, required %0d", name, m_sae, exp_sae);
      end
      checks++;
      if (m_err !== exp_err) begin
         fails++; $display("FAIL %s m_err: got %b, required %b", name, m_err, exp_err);
      end
      if (!hold) begin
         @(posedge clk); #1;
         checks++;
         if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s release: m_valid=%b s_ready=%b, required 0 1", name, m_valid, s_ready);
         end
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_mv_x !== '0 || m_mv_y !== '0 ||
          m_sae !== '0 || m_err !== 1'b0) begin
         fails++;
         $display("FAIL %s: valid=%b ready=%b mv=(%0d,%0d) sae=%0d err=%b, required all 0",
                  name, m_valid, s_ready, m_mv_x, m_mv_y, m_sae, m_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_hold");
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
      end
   endtask

   task automatic test_center_min();
      for (int i = 0; i < NC; i++) sae_q[i] = 16'd1000;
      sae_q[480] = 16'd7;
      run_frame("center_min", NC, NC - 1, 1'b0);
   endtask

   task automatic test_tie();
      fill(10, 60000);
      sae_q[0] = 16'd3;
      sae_q[NC - 1] = 16'd3;
      run_frame("tie_first", NC, NC - 1, 1'b0);
   endtask

   task automatic test_early_last();
      fill(10, 60000);
      sae_q[99] = 16'd0;
      run_frame("early_last", 100, 99, 1'b0);
      fill(10, 60000);
      sae_q[$urandom_range(NC - 1, 0)] = 16'd4;
      run_frame("restart_after_early", NC, NC - 1, 1'b0);
   endtask

   task automatic test_no_last();
      fill(10, 60000);
      sae_q[NC - 1] = 16'd1;
      run_frame("no_last", NC, -1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic stable;
      fill(10, 60000);
      sae_q[$urandom_range(NC - 1, 0)] = 16'd7;
      run_frame("bp_frame", NC, NC - 1, 1'b1);
      for (int i = 0; i < NC; i++) sae_q[i] = 16'hFFFF;
      s_valid = 1'b1;
      s_sae = 16'hFFFF;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_mv_x !== exp_x || m_mv_y !== exp_y ||
             m_sae !== exp_sae || m_err !== exp_err) stable = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         fails++;
         $display("FAIL bp_hold: ready=%b valid=%b sae=%0d, required 0 1 %0d", s_ready, m_valid, m_sae, exp_sae);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
      end
      run_frame("bp_next_first_load", NC, NC - 1, 1'b0);
   endtask

   task automatic test_reset_midframe();
      bit ok;
      fill(10, 60000);
      sae_q[200] = 16'd2;
      m_ready = 1'b1;
      drive_beats(500, -1, ok);
      checks++;
      if (!ok) begin
         fails++; $display("FAIL midframe_drive timeout: s_ready=%b, required 1", s_ready);
      end
      rst = 1'b1;
      #2;
      check_zero("midframe_reset_async");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      fill(10, 60000);
      sae_q[$urandom_range(NC - 1, 0)] = 16'd9;
      run_frame("after_reset", NC, NC - 1, 1'b0);
   endtask

   task automatic test_random();
      int last_at;
      for (int f = 0; f < 4; f++) begin
         fill(0, 15);
         case ($urandom_range(2, 0))
            0:       last_at = NC - 1;
            1:       last_at = $urandom_range(NC - 2, 0);
            default: last_at = -1;
         endcase
         run_frame("random", (last_at < 0) ? NC : last_at + 1, last_at, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_center_min();
      test_tie();
      test_early_last();
      test_no_last();
      test_backpressure();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
